// File: rtl/pll_sys_divgen_pkg.sv
// Shared types and constants for the pll_sys_divgen clock-divider generator.
// Optional per-channel duty control is enabled with PLL_SYS_DIVGEN_DUTY_EN.
package pll_sys_divgen_pkg;

    localparam int unsigned MIN_DIV       = 2;
    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        SETTLE,
        LOCKED,
        PEND
    } lock_state_e;

    // Channel configuration record at the default counter width.
    typedef struct packed {
        logic [CNT_W_DEFAULT-1:0] div;
        logic [CNT_W_DEFAULT-1:0] phase;
`ifdef PLL_SYS_DIVGEN_DUTY_EN
        logic [CNT_W_DEFAULT-1:0] duty;
`endif
    } ch_cfg_t;

endpackage

// File: rtl/pll_sys_divgen_ch.sv
// One divider channel: counter, shadow config, wrap-aligned apply, output flops.
// Build with PLL_SYS_DIVGEN_DUTY_EN to add a programmable high time.
module pll_sys_divgen_ch
    import pll_sys_divgen_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned DIV_DEFAULT = 4
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic [CNT_W-1:0] wr_phase,
`ifdef PLL_SYS_DIVGEN_DUTY_EN
    input  logic [CNT_W-1:0] wr_duty,
`endif
    output logic             outclk,
    output logic             outstb,
    output logic             apply_done
);

    typedef struct packed {
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] phase;
`ifdef PLL_SYS_DIVGEN_DUTY_EN
        logic [CNT_W-1:0] duty;
`endif
    } cfg_t;

    cfg_t             cur_q;
    cfg_t             shadow_q;
    logic             pend_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] duty;
    logic             wrap;

`ifdef PLL_SYS_DIVGEN_DUTY_EN
    assign duty = cur_q.duty;
`else
    assign duty = cur_q.div >> 1;
`endif

    assign wrap = (cnt_q == (cur_q.div - CNT_W'(1)));

    // A disabled channel has no period to protect, so it takes the shadow at once.
    assign apply_done = pend_q && (!en || wrap);

    always_ff @(posedge refclk) begin
        if (rst) begin
            cur_q.div   <= CNT_W'(DIV_DEFAULT);
            cur_q.phase <= '0;
`ifdef PLL_SYS_DIVGEN_DUTY_EN
            cur_q.duty  <= CNT_W'(DIV_DEFAULT >> 1);
`endif
            shadow_q    <= '0;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            outclk      <= 1'b0;
            outstb      <= 1'b0;
        end else begin
            outclk <= en && (cnt_q < duty);
            outstb <= en && (cnt_q == '0);

            if (apply_done) begin
                cur_q  <= shadow_q;
                cnt_q  <= shadow_q.phase;
                pend_q <= 1'b0;
            end else if (!en) begin
                cnt_q <= cur_q.phase;
            end else if (wrap) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (wr) begin
                shadow_q.div   <= wr_div;
                shadow_q.phase <= wr_phase;
`ifdef PLL_SYS_DIVGEN_DUTY_EN
                shadow_q.duty  <= wr_duty;
`endif
                pend_q         <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pll_sys_divgen.sv
// Multi-channel divided-clock/strobe generator with lock sequencer (refclk domain).
// Define PLL_SYS_DIVGEN_DUTY_EN to add the cfg_duty input.
module pll_sys_divgen
    import pll_sys_divgen_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned DIV_DEFAULT = 4,
    parameter int unsigned LOCK_CYCLES = 256,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
`ifdef PLL_SYS_DIVGEN_DUTY_EN
    input  logic [CNT_W-1:0]  cfg_duty,
`endif
    output logic              cfg_ready,
    output logic              cfg_err,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] outstb,
    output logic              locked
);

    localparam int unsigned LCNT_W = $clog2(LOCK_CYCLES + 1);

    lock_state_e       state_q;
    logic [LCNT_W-1:0] lock_cnt_q;
    logic              accept;
    logic [CNT_W-1:0]  phase_eff;
    logic [NUM_CH-1:0] apply_vec;

    // Out-of-range channel numbers are rejected so a write can never strand PEND.
    assign accept = cfg_wr && cfg_ready && (cfg_div >= CNT_W'(MIN_DIV))
                    && (32'(cfg_ch) < NUM_CH);

    assign phase_eff = (cfg_phase >= cfg_div) ? '0 : cfg_phase;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pll_sys_divgen_ch #(
            .CNT_W       (CNT_W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_ch (
            .refclk     (refclk),
            .rst        (rst),
            .en         (ch_en[i]),
            .wr         (accept && (cfg_ch == CH_W'(i))),
            .wr_div     (cfg_div),
            .wr_phase   (phase_eff),
`ifdef PLL_SYS_DIVGEN_DUTY_EN
            .wr_duty    (cfg_duty),
`endif
            .outclk     (outclk[i]),
            .outstb     (outstb[i]),
            .apply_done (apply_vec[i])
        );
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= SETTLE;
            lock_cnt_q <= '0;
            locked     <= 1'b0;
            cfg_ready  <= 1'b1;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= cfg_wr && !accept;
            unique case (state_q)
                SETTLE: begin
                    if (accept) begin
                        state_q   <= PEND;
                        locked    <= 1'b0;
                        cfg_ready <= 1'b0;
                    end else if (lock_cnt_q == LCNT_W'(LOCK_CYCLES - 1)) begin
                        state_q <= LOCKED;
                        locked  <= 1'b1;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + LCNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        state_q   <= PEND;
                        locked    <= 1'b0;
                        cfg_ready <= 1'b0;
                    end
                end
                PEND: begin
                    if (|apply_vec) begin
                        state_q    <= SETTLE;
                        lock_cnt_q <= '0;
                        cfg_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= SETTLE;
                    lock_cnt_q <= '0;
                    locked     <= 1'b0;
                    cfg_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_sys_divgen.sv
// Self-checking bench for pll_sys_divgen: reset vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_pll_sys_divgen;
    import pll_sys_divgen_pkg::*;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 16;
    localparam int DIV_DEFAULT = 4;
    localparam int LOCK_CYCLES = 8;

    localparam int MS_SETTLE = 0;
    localparam int MS_LOCKED = 1;
    localparam int MS_PEND   = 2;

    logic              refclk = 1'b0;
    logic              rst;
    logic              cfg_wr;
    logic [1:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [CNT_W-1:0]  cfg_phase;
`ifdef PLL_SYS_DIVGEN_DUTY_EN
    logic [CNT_W-1:0]  cfg_duty;
`endif
    logic              cfg_ready;
    logic              cfg_err;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] outclk;
    logic [NUM_CH-1:0] outstb;
    logic              locked;

    int n_tests = 0;
    int n_fail  = 0;

    pll_sys_divgen #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
`ifdef PLL_SYS_DIVGEN_DUTY_EN
        .cfg_duty  (cfg_duty),
`endif
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .ch_en     (ch_en),
        .outclk    (outclk),
        .outstb    (outstb),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Behavioural model state
    ch_cfg_t     m_cur [NUM_CH];
    ch_cfg_t     m_shd [NUM_CH];
    int          m_pos [NUM_CH];
    bit          m_pend[NUM_CH];
    logic [3:0]  m_clk, m_stb;
    bit          m_locked, m_ready, m_err;
    int          m_mode, m_settle;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int high_time(input int c);
`ifdef PLL_SYS_DIVGEN_DUTY_EN
        return int'(m_cur[c].duty);
`else
        return int'(m_cur[c].div) / 2;
`endif
    endfunction

    task automatic model_step();
        bit acc;
        bit any_apply;
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_cur[c].div   = 16'(DIV_DEFAULT);
                m_cur[c].phase = '0;
`ifdef PLL_SYS_DIVGEN_DUTY_EN
                m_cur[c].duty  = 16'(DIV_DEFAULT / 2);
`endif
                m_pos[c]  = 0;
                m_pend[c] = 0;
            end
            m_clk = '0; m_stb = '0;
            m_locked = 0; m_ready = 1; m_err = 0;
            m_mode = MS_SETTLE; m_settle = 0;
            return;
        end
        acc = cfg_wr && m_ready && (int'(cfg_div) >= 2);
        m_err = cfg_wr && !acc;
        any_apply = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            bit en = ch_en[c];
            int d  = int'(m_cur[c].div);
            m_clk[c] = en && (m_pos[c] < high_time(c));
            m_stb[c] = en && (m_pos[c] == 0);
            if (m_pend[c] && (!en || m_pos[c] == d - 1)) begin
                m_cur[c]  = m_shd[c];
                m_pos[c]  = int'(m_shd[c].phase);
                m_pend[c] = 0;
                any_apply = 1;
            end else if (!en) begin
                m_pos[c] = int'(m_cur[c].phase);
            end else begin
                m_pos[c] = (m_pos[c] + 1) % d;
            end
            if (acc && int'(cfg_ch) == c) begin
                m_shd[c].div   = cfg_div;
                m_shd[c].phase = (cfg_phase >= cfg_div) ? '0 : cfg_phase;
`ifdef PLL_SYS_DIVGEN_DUTY_EN
                m_shd[c].duty  = cfg_duty;
`endif
                m_pend[c] = 1;
            end
        end
        if (acc) begin
            m_mode = MS_PEND; m_locked = 0; m_ready = 0;
        end else if (m_mode == MS_SETTLE) begin
            if (m_settle == LOCK_CYCLES - 1) begin
                m_mode = MS_LOCKED; m_locked = 1;
            end else begin
                m_settle++;
            end
        end else if (m_mode == MS_PEND && any_apply) begin
            m_mode = MS_SETTLE; m_settle = 0; m_ready = 1;
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        model_step();
        @(negedge refclk);
        check("outclk", 32'(outclk), 32'(m_clk));
        check("outstb", 32'(outstb), 32'(m_stb));
        check("locked", 32'(locked), 32'(m_locked));
        check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    task automatic cfg_write(input int ch, input int div, input int ph);
        cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_div = 16'(div); cfg_phase = 16'(ph);
`ifdef PLL_SYS_DIVGEN_DUTY_EN
        cfg_duty = 16'(div / 2);
`endif
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (cfg_ready !== 1'b1 && k < 32) begin
            tick();
            k++;
        end
        check({name, " ready timeout"}, 32'(k < 32), 32'd1);
    endtask

    task automatic strobe_period(input int c, output int per);
        int k = 0;
        while (outstb[c] !== 1'b1 && k < 32) begin
            tick();
            k++;
        end
        per = 0;
        do begin
            tick();
            per++;
        end while (outstb[c] !== 1'b1 && per < 32);
    endtask

    typedef struct {
        logic [3:0] en;
        logic       clk0;
        logic       stb0;
        logic       lck;
        logic       rdy;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int per;
        int k;
        logic exp_clk[8];
        logic exp_clk_init[8] = '{0, 0, 0, 1, 1, 0, 0, 0};
        exp_clk = exp_clk_init;

        // Cycles 1..12 after reset release with every channel enabled
        vecs[0]  = '{4'hF, 0, 0, 0, 1};
        vecs[1]  = '{4'hF, 1, 1, 0, 1};
        vecs[2]  = '{4'hF, 1, 0, 0, 1};
        vecs[3]  = '{4'hF, 0, 0, 0, 1};
        vecs[4]  = '{4'hF, 0, 0, 0, 1};
        vecs[5]  = '{4'hF, 1, 1, 0, 1};
        vecs[6]  = '{4'hF, 1, 0, 0, 1};
        vecs[7]  = '{4'hF, 0, 0, 0, 1};
        vecs[8]  = '{4'hF, 0, 0, 1, 1};
        vecs[9]  = '{4'hF, 1, 1, 1, 1};
        vecs[10] = '{4'hF, 1, 0, 1, 1};
        vecs[11] = '{4'hF, 0, 0, 1, 1};

        rst = 1'b1; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
`ifdef PLL_SYS_DIVGEN_DUTY_EN
        cfg_duty = '0;
`endif
        ch_en = 4'hF;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ch_en = vecs[i].en;
            check($sformatf("vec%0d outclk0", i + 1), 32'(outclk[0]), 32'(vecs[i].clk0));
            check($sformatf("vec%0d outstb0", i + 1), 32'(outstb[0]), 32'(vecs[i].stb0));
            check($sformatf("vec%0d locked", i + 1), 32'(locked), 32'(vecs[i].lck));
            check($sformatf("vec%0d cfg_ready", i + 1), 32'(cfg_ready), 32'(vecs[i].rdy));
            tick();
        end

        // Reconfigure ch1 to div 5, phase 2
        cfg_write(1, 5, 2);
        check("wr1 cfg_ready low", 32'(cfg_ready), 32'd0);
        check("wr1 locked low", 32'(locked), 32'd0);
        wait_ready("wr1");
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("ch1 outclk t%0d", i + 1), 32'(outclk[1]), 32'(exp_clk[i]));
            check($sformatf("relock t%0d", i + 1), 32'(locked), 32'(i == 7));
        end

        // Rejected divide ratio
        cfg_write(0, 1, 0);
        check("div1 cfg_err", 32'(cfg_err), 32'd1);
        check("div1 locked", 32'(locked), 32'd1);
        check("div1 cfg_ready", 32'(cfg_ready), 32'd1);
        tick();
        check("div1 cfg_err single", 32'(cfg_err), 32'd0);
        check("div1 locked held", 32'(locked), 32'd1);

        // Second write while busy is dropped; first still applies
        cfg_write(3, 6, 0);
        check("wr3 cfg_ready low", 32'(cfg_ready), 32'd0);
        cfg_write(3, 3, 0);
        check("busy write cfg_err", 32'(cfg_err), 32'd1);
        wait_ready("wr3");
        strobe_period(3, per);
        check("ch3 period", 32'(per), 32'd6);

        // Disable ch2 during its high phase, then re-enable
        k = 0;
        while (!(outclk[2] === 1'b1 && outstb[2] === 1'b0) && k < 16) begin
            tick();
            k++;
        end
        check("ch2 high wait timeout", 32'(k < 16), 32'd1);
        ch_en[2] = 1'b0;
        tick();
        check("ch2 off outclk", 32'(outclk[2]), 32'd0);
        check("ch2 off outstb", 32'(outstb[2]), 32'd0);
        tick();
        tick();
        ch_en[2] = 1'b1;
        tick();
        check("ch2 on outclk", 32'(outclk[2]), 32'd1);
        check("ch2 on outstb", 32'(outstb[2]), 32'd1);

        // Reset while a write is pending
        cfg_write(0, 7, 3);
        check("wr0 cfg_ready low", 32'(cfg_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post-rst cfg_ready", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("post-rst locked t%0d", i + 1), 32'(locked), 32'(i == 7));
        end
        strobe_period(0, per);
        check("ch0 period after rst", 32'(per), 32'd4);
        strobe_period(1, per);
        check("ch1 period after rst", 32'(per), 32'd4);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            cfg_wr    = ($urandom_range(0, 11) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_div   = 16'($urandom_range(0, 9));
            cfg_phase = 16'($urandom_range(0, 11));
`ifdef PLL_SYS_DIVGEN_DUTY_EN
            cfg_duty  = 16'($urandom_range(0, 10));
`endif
            if ($urandom_range(0, 15) == 0) ch_en = ch_en ^ (4'b0001 << $urandom_range(0, 3));
            rst = ($urandom_range(0, 249) == 0);
            tick();
        end
        cfg_wr = 1'b0;
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_sys_divgen.md
Name: pll_sys_divgen

Overview:
- Parametrised multi-channel clock-enable/divided-clock generator with a lock sequencer. It is the next generation of the system PLL wrapper.
- Runs entirely in the refclk domain. Produces NUM_CH registered divided clocks plus matching one-cycle strobes.
- Per-channel divide ratio and phase are runtime-programmable and applied glitch-free. The locked indication drops across reconfiguration.
- Feeds UART baud timing and peripheral enables in the UART_IO system.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- CNT_W, 16, width of divide/phase counters.
- DIV_DEFAULT, 4, divide ratio loaded at reset into every channel (>=2).
- LOCK_CYCLES, 256, settle cycles before locked asserts (>=1).

Ports:
- refclk, in, 1, sole clock; all logic on its rising edge.
- rst, in, 1, synchronous active-high reset.
- cfg_wr, in, 1, configuration write strobe.
- cfg_ch, in, $clog2(NUM_CH) (min 1), target channel.
- cfg_div, in, CNT_W, new divide ratio N.
- cfg_phase, in, CNT_W, counter start value on apply/enable.
- cfg_ready, out, 1, write accepted when high.
- cfg_err, out, 1, one-cycle pulse on rejected write.
- ch_en, in, NUM_CH, per-channel run enable.
- outclk, out, NUM_CH, divided clocks (registered).
- outstb, out, NUM_CH, one-cycle strobe per period.
- locked, out, 1, all channels running stable configuration.

Behaviour:
- Reset values (in and after reset cycles):
  - outclk=0, outstb=0, locked=0, cfg_err=0, cfg_ready=1.
  - Per channel: div=DIV_DEFAULT, phase=0, cnt=0.
  - Pending writes are discarded.
- Channel counter: when enabled, cnt increments each cycle and wraps at div-1 back to 0.
- Output latency is 1 cycle:
  - outclk(t+1) = ch_en && cnt(t) < (div>>1).
  - outstb(t+1) = ch_en && cnt(t)==0.
  - The first cycle after rst release still shows 0s; the second cycle shows outclk=1 and outstb=1.
- Odd N: high time is N>>1 cycles, low time is N-(N>>1) cycles.
- Phase: if cfg_phase >= cfg_div, 0 is used.
- ch_en low:
  - cnt is held at phase; outclk=0 and outstb=0 from the next cycle.
  - On re-enable, counting restarts from phase.
- Config write:
  - Accepted when cfg_wr && cfg_ready && cfg_div>=2; the value goes to the channel shadow register.
  - cfg_wr with cfg_div<2, or with cfg_ready=0, is ignored and cfg_err pulses the next cycle.
  - Accept deasserts cfg_ready and locked on the next cycle.
- Apply timing:
  - Enabled channel: shadow is applied on the channel's next wrap (cnt==div-1 → cnt=phase). This gives no runt pulses.
  - If the write coincides with a wrap, it applies at the following wrap.
  - Disabled channel: applied the next cycle.
  - If ch_en falls while pending, the value applies the next cycle.
- Lock FSM, states SETTLE, LOCKED, PEND:
  - Reset → SETTLE with lock_cnt=0.
  - SETTLE counts; at lock_cnt==LOCK_CYCLES-1 → LOCKED, so locked=1 LOCK_CYCLES+1 cycles after rst release.
  - Accepted write from any state → PEND with locked=0 and cfg_ready=0.
  - PEND → SETTLE with lock_cnt=0 once the apply completes; cfg_ready returns to 1 on entry to SETTLE.
  - ch_en changes do not affect locked.
- rst asserted mid-operation overrides everything, including PEND.

Optional Feature:
- Macro: PLL_SYS_DIVGEN_DUTY_EN.
- Defined:
  - Adds input cfg_duty (CNT_W), shadowed and applied with cfg_div.
  - outclk(t+1) = ch_en && cnt(t) < duty.
  - duty=0 gives constant low; duty>=div gives constant high. outstb is unchanged.
- Undefined: no port; duty is fixed at div>>1.

Decomposition:
- Package pll_sys_divgen_pkg holds:
  - Lock FSM state enum {SETTLE, LOCKED, PEND}.
  - MIN_DIV=2 and CNT_W_DEFAULT=16.
  - The channel config struct {div, phase[, duty]}.
- Sub-module pll_sys_divgen_ch holds one channel's counter, shadow register, apply logic and output flops. It is instantiated NUM_CH times by generate, and reports an apply_done pulse to the top-level FSM.

Test Plan (NUM_CH=4, DIV_DEFAULT=4, LOCK_CYCLES=8):
- Reset release, ch_en=4'hF:
  - outclk[0] is 0 on cycle 1, then 1,1,0,0 repeating.
  - outstb[0] pulses on cycles 2, 6, 10.
  - locked rises on cycle 9.
- Running, locked=1; write ch1 div=5 phase=2:
  - Next cycle cfg_ready=0 and locked=0.
  - After ch1 wrap, counting from 2 gives outclk[1] low 3 cycles, high 2, then period 5.
  - locked returns 8 cycles after apply.
- Write div=1: cfg_err pulses once; no config change; locked stays 1.
- Second write while cfg_ready=0 → cfg_err pulse; ignored; the first write still applies.
- ch_en[2] low mid-high-phase → outclk[2]=0 next cycle. Re-enable with phase=0 → outclk[2]=1 and outstb[2]=1 one cycle later.
- rst pulse while in PEND → pending write lost; all channels back to div 4; locked after 8 cycles.
